seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits, such as the 4-digit display on the Basys board.
- Scans one digit per refresh slot and decodes that digit's hex nibble to active-low segments.
- Takes a new display value through a load strobe and applies it only at a frame boundary, so a scan never shows a mix of old and new digits.
- Sits between the processor's display/IO register and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); digit 0 is the rightmost (AN0).
REFRESH_DIV, 100000, clk cycles each digit stays lit (>=1); use 4 in simulation.
DIV_W, $clog2(REFRESH_DIV) (minimum 1), width of the refresh divider counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
value  in  4*NUM_DIGITS  hex value to show; nibble i drives digit i
load  in  1  one-cycle strobe that captures value
digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
seg  out  7  segments, active-low; seg[6]=a ... seg[0]=g
an  out  NUM_DIGITS  anode selects, active-low, at most one low at a time
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, active-high) clears all state:
  - div_cnt=0, digit_idx=0, shadow=0, active=0, pending=0.
  - Outputs: an=all ones, seg=7'b1111111, frame_tick=0.
- Refresh divider:
  - div_cnt counts 0..REFRESH_DIV-1 and then wraps.
  - slot_end is asserted when div_cnt==REFRESH_DIV-1.
  - On slot_end, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
- Frame boundary: slot_end with digit_idx==NUM_DIGITS-1.
  - On that cycle frame_tick=1, registered, visible the next cycle.
  - If pending, active<=shadow and pending<=0.
- load:
  - shadow<=value and pending<=1 on the same edge.
  - If load coincides with a frame boundary, active<=value directly and pending<=0; the new value takes effect at the new frame.
  - Repeated loads within one frame: the last one wins.
- Outputs are registered and update on the edge after digit_idx changes (1-cycle latency).
  - an: bit digit_idx is 0, all other bits are 1.
  - seg: decode of active[4*digit_idx+:4].
- Blanked digit (digit_en[digit_idx]=0):
  - an stays all ones and seg=7'b1111111 for that slot.
  - The slot length is unchanged, so scan timing does not depend on digit_en.
- Decode table (abcdefg, active-low):
  - 0:0000001 1:1001111 2:0010010 3:0000110
  - 4:1001100 5:0100100 6:0100000 7:0001111
  - 8:0000000 9:0001100 A:0001000 b:1100000
  - C:0110001 d:1000010 E:0110000 F:0111000
- REFRESH_DIV=1: digit_idx advances every cycle and every NUM_DIGITS-th cycle is a frame boundary.
- NUM_DIGITS=1: every slot_end is a frame boundary and an is a constant 0 except when blanked.
- Reset mid-scan: outputs return to blank immediately (async); scanning restarts from digit 0 on the first edge after release; any pending load is discarded.

Optional Feature:
SEG7_ZERO_BLANK_EN
- Defined: leading-zero suppression. Digit i is blanked if active nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed, so the value 0 shows a single "0". digit_en masking still applies on top.
- Undefined: every enabled digit is shown, including leading zeros.

Test Plan:
- Scan order: NUM_DIGITS=4, REFRESH_DIV=4, reset, load value=16'h1234, digit_en=4'hF.
  - an cycles 1110,1101,1011,0111, each held 4 cycles.
  - seg = 1001100, 0000110, 0010010, 1001111 (digits 4,3,2,1 in slot order 0..3).
  - frame_tick pulses every 16 cycles.
- Frame-synchronous update: load 16'hABCD, then load 16'h00EF in digit slot 1.
  - Digits 2 and 3 still show B and A for the rest of that frame.
  - The next frame shows F, E, 0, 0.
- Simultaneous load and frame boundary: load 16'h5555 on the boundary cycle.
  - Slot 0 of the next frame shows 0100100 and pending stays 0.
- Blanking: digit_en=4'b1010.
  - Slots 0 and 2 give an=1111 and seg=1111111 for 4 cycles each.
  - Slots 1 and 3 drive normally.
- Async reset mid-slot: assert reset between edges during slot 2.
  - an=1111 and seg=1111111 immediately; active=0.
  - After release, the first lit slot is digit 0 showing 0000001.
- SEG7_ZERO_BLANK_EN defined, value 16'h0070: digits 3 and 2 blank, digit 1 = 0001111, digit 0 = 0000001. value 16'h0000: only digit 0 lit, showing 0000001.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// One digit is lit per refresh slot. That digit's hex nibble is decoded to
// active-low segments. A new display value arrives through a load strobe. It
// is held in a shadow register and copied to the active register only at a
// frame boundary, so a single scan never mixes old and new digits.
//
// Parameters:
//   NUM_DIGITS  - number of digits scanned (1..8); digit 0 is the rightmost
//   REFRESH_DIV - clk cycles each digit stays lit (>= 1)
//   DIV_W       - width of the refresh divider counter
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   value      in   hex value to show; nibble i drives digit i
//   load       in   one-cycle strobe that captures value
//   digit_en   in   per-digit enable; 0 blanks that digit
//   seg        out  segments, active-low; seg[6]=a ... seg[0]=g
//   an         out  anode selects, active-low, at most one low at a time
//   frame_tick out  one-cycle pulse after each frame boundary
//
// Optional feature:
//   SEG7_ZERO_BLANK_EN - when defined, leading zeros are suppressed. Digit 0
//   is never suppressed, and digit_en masking still applies.
// -----------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic                    show;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   suppressed;
    logic                    zero_above;

    // Hex nibble to abcdefg, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // NOTE: combinational logic uses blocking assignments. Every output gets
    // a default at the top, so no path can leave a value held and infer a latch.
    always_comb begin
        slot_end   = (div_cnt == DIV_LAST);
        frame_end  = slot_end && (digit_idx == IDX_LAST);
        cur_nib    = active[4*digit_idx +: 4];
        show       = digit_en[digit_idx];
        suppressed = '0;
        zero_above = 1'b1;
`ifdef SEG7_ZERO_BLANK_EN
        // Walk down from the most significant digit. A digit is a leading
        // zero while it and every digit above it are zero. Digit 0 is excluded.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (active[4*i +: 4] == 4'h0);
            suppressed[i] = zero_above;
        end
        show = show && !suppressed[digit_idx];
`endif
        an_next = '1;
        if (show) an_next[digit_idx] = 1'b0;
        seg_next = show ? hex_to_seg(cur_nib) : SEG_OFF;
    end

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever order the statements are in.
    // The display registers are small flops rather than a memory, so they are
    // reset together with the rest of the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end

            // Outputs describe the slot that was current before this edge.
            an         <= an_next;
            seg        <= seg_next;
            frame_tick <= frame_end;

            // A load on the boundary goes straight to active. Otherwise the
            // shadow waits for the next boundary, and the latest load wins.
            if (load) begin
                shadow <= value;
                if (frame_end) begin
                    active  <= value;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule
